phold_sched: RTL and testbench
==============================

Name: phold_sched

Overview:
Parametrised PHOLD scheduler for NCORE cores.
- Seeds the event queue with NINIT initial events.
- Arbitrates new events from cores into an external priority queue.
- Dispatches the queue head to idle cores round-robin.
- Maintains a monotonic GVT over in-flight events plus the queue head.
- Terminates on end-time crossing or deadlock.

Sits between the `prio_q` instance and the `phold_core` array in the simulation top level.

Parameters:
- NCORE, 4, number of cores (2..16).
- TW, 16, timestamp width.
- LPW, 3, LP id width; event word DW = LPW+TW, {lp, time}.
- NINIT, 4, initial events seeded at time 0, LP ids 0..NINIT-1 (NINIT <= 2^LPW).
- CW, 5, queue occupancy count width.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin run; sampled only in IDLE.
- end_time, in, TW, simulation end time; sampled into a register on start.
- core_ready, in, NCORE, core idle and able to accept an event.
- core_evt_vld, out, NCORE, one-hot dispatch strobe.
- core_evt_data, out, DW, dispatched event, = q_rdata.
- core_new_vld, in, NCORE, core holds a new event.
- core_new_data, in, NCORE*DW, new event of core i at [i*DW +: DW].
- core_ack, out, NCORE, one-hot accept of a new event.
- q_enq, out, 1, queue enqueue.
- q_wdata, out, DW, enqueue data.
- q_deq, out, 1, queue dequeue (head consumed this cycle).
- q_rdata, in, DW, queue head, minimum time.
- q_count, in, CW, queue occupancy.
- q_full, in, 1, queue full.
- gvt, out, TW, global virtual time.
- rtn_vld, out, 1, one-cycle completion pulse.
- err, out, 1, completion was due to deadlock; valid with rtn_vld.
- busy, out, 1, state is not IDLE.

Behaviour:
Reset:
- State IDLE.
- gvt=0, rtn_vld=0, err=0.
- All active flags and per-core times cleared; both round-robin pointers 0.
- All combinational strobes are 0 in IDLE.

States:
- IDLE: on start, register end_time, clear gvt, go to INIT.
- INIT: one seed per cycle, q_enq=1, q_wdata={idx, TW'b0}, idx 0..NINIT-1.
  - Stall (no enq, idx held) while q_full.
  - After the last seed is enqueued, go to RUN.
- RUN:
  - Enqueue has priority. If any core_new_vld and !q_full: round-robin grant g, core_ack[g]=1, q_enq=1, q_wdata=core data g, all in the same cycle.
  - Else dispatch when any core_ready and q_count!=0: round-robin grant d, core_evt_vld[d]=1, q_deq=1.
  - Never dispatch from an empty queue; never enqueue into a full queue.
  - Enqueue and dequeue are mutually exclusive in a cycle.
- DONE: rtn_vld=1 and err per cause, for exactly one cycle, then IDLE.

Arbitration:
- Independent enqueue and dispatch pointers.
- Search starts at pointer, ascending with wrap.
- After a grant, pointer <= grant+1 mod NCORE. Pointer holds when there is no grant.

Tracking, registered:
- On dispatch to d: loc_time[d] <= event time, act[d] <= 1.
- On ack of g: act[g] <= 0. The flag is indexed by the granted core, not by a request vector.

GVT:
- cand = min over {loc_time[i] | act[i]} and {q_rdata time | q_count!=0}.
- In RUN, if cand exists: gvt <= max(gvt, cand). Registered, 1-cycle latency; gvt never decreases.
- Otherwise gvt holds. gvt also holds outside RUN.

Termination, evaluated in RUN:
- gvt > end_time (strict) -> DONE with err=0.
- Else q_count==0, no act bits set and no core_new_vld -> DONE with err=1.
- Both checks take priority over grants in that cycle.

Reset mid-run returns to IDLE asynchronously; the external queue is cleared by the shared rst_n.

Test Plan:
1. NCORE=4, NINIT=4, start -> 4 consecutive q_enq with q_wdata lp 0..3, time 0; RUN entered on the 5th cycle; gvt stays 0.
2. INIT with q_full asserted for 3 cycles at seed 2 -> seed 2 enqueued exactly once after q_full drops; total of 4 enqueues.
3. All cores ready, queue holds 4 events -> core_evt_vld grants 0,1,2,3 in order; 5th grant wraps to 0; no q_deq when q_count==0.
4. core_new_vld on cores 1 and 3 while core 0 is ready -> ack 1, then ack 3, then dispatch to 0; act[1] and act[3] clear on their acks.
5. Active loc_times {10,_,7,_}, queue head 5 -> gvt=5 the next cycle; after head 5 is dispatched and no event <=7 remains -> gvt=7; a later smaller cand does not lower gvt.
6. end_time=20, gvt reaches 21 -> one-cycle rtn_vld with err=0, then busy=0. Separately, drain all events with no new ones -> rtn_vld with err=1.

Source files
------------

// File: rtl/phold_sched.sv
// PHOLD scheduler: seeds the external priority queue, arbitrates new events from
// the cores into it, dispatches the queue head to idle cores and maintains GVT.
module phold_sched #(
  parameter int NCORE = 4,
  parameter int TW    = 16,
  parameter int LPW   = 3,
  parameter int NINIT = 4,
  parameter int CW    = 5,
  localparam int DW   = LPW + TW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [TW-1:0]       end_time,
  input  logic [NCORE-1:0]    core_ready,
  output logic [NCORE-1:0]    core_evt_vld,
  output logic [DW-1:0]       core_evt_data,
  input  logic [NCORE-1:0]    core_new_vld,
  input  logic [NCORE*DW-1:0] core_new_data,
  output logic [NCORE-1:0]    core_ack,
  output logic                q_enq,
  output logic [DW-1:0]       q_wdata,
  output logic                q_deq,
  input  logic [DW-1:0]       q_rdata,
  input  logic [CW-1:0]       q_count,
  input  logic                q_full,
  output logic [TW-1:0]       gvt,
  output logic                rtn_vld,
  output logic                err,
  output logic                busy
);

  // Handshakes: a core's new event is consumed in the cycle its core_ack is high;
  // core_evt_vld is a one-cycle strobe offered only to a core showing core_ready;
  // q_enq and q_deq are one-cycle strobes and never coincide.
  localparam int PW = $clog2(NCORE);
  localparam int IW = LPW + 1;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     end_time_q, end_time_d;
  logic [TW-1:0]     gvt_q, gvt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     enq_ptr_q, enq_ptr_d;
  logic [PW-1:0]     deq_ptr_q, deq_ptr_d;
  logic [NCORE-1:0]  act_q, act_d;
  logic              err_q, err_d;
  logic [TW-1:0]     loc_time_q [NCORE];

  logic [PW:0]       enq_pick, deq_pick;
  logic [PW-1:0]     enq_idx, deq_idx;
  logic              cand_vld;
  logic [TW-1:0]     cand;

  function automatic logic [PW:0] rr_pick(input logic [NCORE-1:0] req,
                                          input logic [PW-1:0]    ptr);
    logic [PW:0]   r;
    logic [PW-1:0] c;
    r = '0;
    for (int k = 0; k < NCORE; k++) begin
      c = PW'((int'(ptr) + k) % NCORE);
      if (!r[PW] && req[c]) r = {1'b1, c};
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
    return (g == PW'(NCORE - 1)) ? '0 : g + PW'(1);
  endfunction

  assign enq_pick = rr_pick(core_new_vld, enq_ptr_q);
  assign deq_pick = rr_pick(core_ready, deq_ptr_q);
  assign enq_idx  = enq_pick[PW-1:0];
  assign deq_idx  = deq_pick[PW-1:0];

  // Smallest timestamp still in flight: active cores plus the queue head.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    if (q_count != '0) begin
      cand_vld = 1'b1;
      cand     = q_rdata[TW-1:0];
    end
    for (int i = 0; i < NCORE; i++) begin
      if (act_q[i] && (!cand_vld || loc_time_q[i] < cand)) begin
        cand_vld = 1'b1;
        cand     = loc_time_q[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    end_time_d   = end_time_q;
    gvt_d        = gvt_q;
    idx_d        = idx_q;
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    act_d        = act_q;
    err_d        = err_q;
    core_evt_vld = '0;
    core_ack     = '0;
    q_enq        = 1'b0;
    q_deq        = 1'b0;
    q_wdata      = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          end_time_d = end_time;
          gvt_d      = '0;
          idx_d      = '0;
          act_d      = '0;
          state_d    = S_INIT;
        end
      end
      S_INIT: begin
        if (!q_full) begin
          q_enq   = 1'b1;
          q_wdata = {idx_q[LPW-1:0], {TW{1'b0}}};
          if (idx_q == IW'(NINIT - 1)) state_d = S_RUN;
          else                         idx_d   = idx_q + IW'(1);
        end
      end
      S_RUN: begin
        if (cand_vld && cand > gvt_q) gvt_d = cand;
        // Termination outranks any grant in the same cycle.
        if (gvt_q > end_time_q) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (q_count == '0 && act_q == '0 && core_new_vld == '0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (enq_pick[PW] && !q_full) begin
          q_enq     = 1'b1;
          enq_ptr_d = next_ptr(enq_idx);
          for (int i = 0; i < NCORE; i++) begin
            if (enq_idx == PW'(i)) begin
              core_ack[i] = 1'b1;
              q_wdata     = core_new_data[i*DW +: DW];
              act_d[i]    = 1'b0;
            end
          end
        end else if (deq_pick[PW] && q_count != '0) begin
          q_deq     = 1'b1;
          deq_ptr_d = next_ptr(deq_idx);
          for (int i = 0; i < NCORE; i++) begin
            if (deq_idx == PW'(i)) begin
              core_evt_vld[i] = 1'b1;
              act_d[i]        = 1'b1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      end_time_q <= '0;
      gvt_q      <= '0;
      idx_q      <= '0;
      enq_ptr_q  <= '0;
      deq_ptr_q  <= '0;
      act_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      end_time_q <= end_time_d;
      gvt_q      <= gvt_d;
      idx_q      <= idx_d;
      enq_ptr_q  <= enq_ptr_d;
      deq_ptr_q  <= deq_ptr_d;
      act_q      <= act_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCORE; i++) loc_time_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCORE; i++) begin
        if (core_evt_vld[i]) loc_time_q[i] <= q_rdata[TW-1:0];
      end
    end
  end

  assign core_evt_data = q_rdata;
  assign gvt           = gvt_q;
  assign rtn_vld       = (state_q == S_DONE);
  assign err           = (state_q == S_DONE) && err_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_phold_sched.sv
// Directed bench for phold_sched: INIT seeding, round-robin grants, GVT tracking
// and both termination causes, driven straight through the queue-side ports.
module tb_phold_sched;
  localparam int NCORE = 4;
  localparam int TW    = 16;
  localparam int LPW   = 3;
  localparam int NINIT = 4;
  localparam int CW    = 5;
  localparam int DW    = LPW + TW;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [TW-1:0]       end_time = '0;
  logic [NCORE-1:0]    core_ready = '0;
  logic [NCORE-1:0]    core_evt_vld;
  logic [DW-1:0]       core_evt_data;
  logic [NCORE-1:0]    core_new_vld = '0;
  logic [NCORE*DW-1:0] core_new_data = '0;
  logic [NCORE-1:0]    core_ack;
  logic                q_enq;
  logic [DW-1:0]       q_wdata;
  logic                q_deq;
  logic [DW-1:0]       q_rdata = '0;
  logic [CW-1:0]       q_count = '0;
  logic                q_full = 1'b0;
  logic [TW-1:0]       gvt;
  logic                rtn_vld;
  logic                err;
  logic                busy;

  always #5 clk = ~clk;

  phold_sched #(.NCORE(NCORE), .TW(TW), .LPW(LPW), .NINIT(NINIT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .end_time(end_time),
    .core_ready(core_ready), .core_evt_vld(core_evt_vld), .core_evt_data(core_evt_data),
    .core_new_vld(core_new_vld), .core_new_data(core_new_data), .core_ack(core_ack),
    .q_enq(q_enq), .q_wdata(q_wdata), .q_deq(q_deq), .q_rdata(q_rdata),
    .q_count(q_count), .q_full(q_full), .gvt(gvt), .rtn_vld(rtn_vld),
    .err(err), .busy(busy)
  );

  typedef struct {
    logic [3:0]  rdy;
    logic [3:0]  nv;
    logic [75:0] nd;
    logic [18:0] rd;
    logic [4:0]  cnt;
    logic        full;
    logic [3:0]  e_evt;
    logic [3:0]  e_ack;
    logic        e_enq;
    logic        e_deq;
    logic [18:0] e_wd;
    logic [15:0] e_gvt;
  } vec_t;

  vec_t tbl1[$];
  vec_t tbl2[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   enq_cnt;

  function automatic logic [18:0] ev(input int lp, input int t);
    logic [2:0]  l;
    logic [15:0] tt;
    l  = 3'(lp);
    tt = 16'(t);
    return {l, tt};
  endfunction

  function automatic logic [75:0] p4(input logic [18:0] c3, input logic [18:0] c2,
                                     input logic [18:0] c1, input logic [18:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  function automatic vec_t mk(input logic [3:0] rdy, input logic [3:0] nv,
                              input logic [75:0] nd, input logic [18:0] rd,
                              input logic [4:0] cnt, input logic full,
                              input logic [3:0] e_evt, input logic [3:0] e_ack,
                              input logic e_enq, input logic e_deq,
                              input logic [18:0] e_wd, input logic [15:0] e_gvt);
    vec_t v;
    v.rdy = rdy; v.nv = nv; v.nd = nd; v.rd = rd; v.cnt = cnt; v.full = full;
    v.e_evt = e_evt; v.e_ack = e_ack; v.e_enq = e_enq; v.e_deq = e_deq;
    v.e_wd = e_wd; v.e_gvt = e_gvt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic quiet();
    core_ready   = '0;
    core_new_vld = '0;
    q_full       = 1'b0;
  endtask

  task automatic apply(input vec_t v, input string tag, input int id);
    string n;
    core_ready    = v.rdy;
    core_new_vld  = v.nv;
    core_new_data = v.nd;
    q_rdata       = v.rd;
    q_count       = v.cnt;
    q_full        = v.full;
    @(negedge clk);
    n = $sformatf("%s%0d", tag, id);
    chk({n, " evt_vld"}, 32'(core_evt_vld), 32'(v.e_evt));
    chk({n, " ack"},     32'(core_ack),     32'(v.e_ack));
    chk({n, " q_enq"},   32'(q_enq),        32'(v.e_enq));
    chk({n, " q_deq"},   32'(q_deq),        32'(v.e_deq));
    chk({n, " gvt"},     32'(gvt),          32'(v.e_gvt));
    chk({n, " rtn_vld"}, 32'(rtn_vld),      32'd0);
    chk({n, " busy"},    32'(busy),         32'd1);
    if (v.e_enq) chk({n, " q_wdata"}, 32'(q_wdata), 32'(v.e_wd));
    if (v.e_deq) chk({n, " evt_data"}, 32'(core_evt_data), 32'(v.rd));
    @(posedge clk); #1;
  endtask

  task automatic check_done(input string tag, input logic exp_err, input logic [15:0] exp_gvt);
    quiet();
    @(negedge clk);
    chk({tag, " done rtn_vld"}, 32'(rtn_vld), 32'd1);
    chk({tag, " done err"},     32'(err),     32'(exp_err));
    chk({tag, " done busy"},    32'(busy),    32'd1);
    chk({tag, " done strobes"}, 32'({core_evt_vld, core_ack, q_enq, q_deq}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " idle rtn_vld"}, 32'(rtn_vld), 32'd0);
    chk({tag, " idle err"},     32'(err),     32'd0);
    chk({tag, " idle busy"},    32'(busy),    32'd0);
    chk({tag, " idle gvt"},     32'(gvt),     32'(exp_gvt));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] full_pat;
    int         seed_exp;

    // Run 1: seeding, dispatch round robin, enqueue arbitration, end-time exit.
    tbl1.push_back(mk(4'b0000, 4'b0000, '0, ev(0,0), 5'd4, 0, 4'b0000, 4'b0000, 0, 0, '0, 16'd0));
    tbl1.push_back(mk(4'b1111, 4'b0000, '0, ev(1,2), 5'd4, 0, 4'b0001, 4'b0000, 0, 1, '0, 16'd0));
    tbl1.push_back(mk(4'b1111, 4'b0000, '0, ev(2,3), 5'd3, 0, 4'b0010, 4'b0000, 0, 1, '0, 16'd2));
    tbl1.push_back(mk(4'b1111, 4'b0000, '0, ev(3,5), 5'd2, 0, 4'b0100, 4'b0000, 0, 1, '0, 16'd2));
    tbl1.push_back(mk(4'b1111, 4'b0000, '0, ev(0,6), 5'd1, 0, 4'b1000, 4'b0000, 0, 1, '0, 16'd2));
    tbl1.push_back(mk(4'b1111, 4'b0000, '0, ev(0,9), 5'd0, 0, 4'b0000, 4'b0000, 0, 0, '0, 16'd2));
    tbl1.push_back(mk(4'b1111, 4'b0000, '0, ev(1,7), 5'd1, 0, 4'b0001, 4'b0000, 0, 1, '0, 16'd2));
    tbl1.push_back(mk(4'b0001, 4'b1010, p4(ev(5,4), '0, ev(4,8), '0), ev(0,50), 5'd0, 0,
                      4'b0000, 4'b0010, 1, 0, ev(4,8), 16'd2));
    tbl1.push_back(mk(4'b0001, 4'b1000, p4(ev(5,4), '0, ev(4,8), '0), ev(4,8), 5'd1, 0,
                      4'b0000, 4'b1000, 1, 0, ev(5,4), 16'd3));
    tbl1.push_back(mk(4'b0001, 4'b0000, '0, ev(5,4), 5'd2, 0, 4'b0001, 4'b0000, 0, 1, '0, 16'd5));
    tbl1.push_back(mk(4'b0000, 4'b0101, p4('0, ev(2,25), '0, ev(1,30)), ev(3,22), 5'd1, 0,
                      4'b0000, 4'b0001, 1, 0, ev(1,30), 16'd5));
    tbl1.push_back(mk(4'b0000, 4'b0100, p4('0, ev(2,25), '0, ev(1,30)), ev(3,22), 5'd2, 0,
                      4'b0000, 4'b0100, 1, 0, ev(2,25), 16'd5));
    tbl1.push_back(mk(4'b0000, 4'b0000, '0, ev(3,22), 5'd3, 0, 4'b0000, 4'b0000, 0, 0, '0, 16'd5));
    tbl1.push_back(mk(4'b0001, 4'b0000, '0, ev(3,22), 5'd3, 0, 4'b0000, 4'b0000, 0, 0, '0, 16'd22));

    // Run 2: GVT bounded by active cores and head, enqueue blocked by full, deadlock exit.
    tbl2.push_back(mk(4'b0010, 4'b0000, '0, ev(0,0),  5'd4, 0, 4'b0010, 4'b0000, 0, 1, '0, 16'd0));
    tbl2.push_back(mk(4'b0001, 4'b0000, '0, ev(1,10), 5'd3, 0, 4'b0001, 4'b0000, 0, 1, '0, 16'd0));
    tbl2.push_back(mk(4'b0100, 4'b0000, '0, ev(2,7),  5'd2, 0, 4'b0100, 4'b0000, 0, 1, '0, 16'd0));
    tbl2.push_back(mk(4'b0000, 4'b0010, p4('0, '0, ev(5,5), '0), ev(3,12), 5'd1, 1,
                      4'b0000, 4'b0000, 0, 0, '0, 16'd0));
    tbl2.push_back(mk(4'b0000, 4'b0010, p4('0, '0, ev(5,5), '0), ev(3,12), 5'd1, 0,
                      4'b0000, 4'b0010, 1, 0, ev(5,5), 16'd0));
    tbl2.push_back(mk(4'b0000, 4'b0000, '0, ev(5,5),  5'd2, 0, 4'b0000, 4'b0000, 0, 0, '0, 16'd0));
    tbl2.push_back(mk(4'b0000, 4'b0000, '0, ev(5,5),  5'd2, 0, 4'b0000, 4'b0000, 0, 0, '0, 16'd5));
    tbl2.push_back(mk(4'b1000, 4'b0000, '0, ev(5,5),  5'd2, 0, 4'b1000, 4'b0000, 0, 1, '0, 16'd5));
    tbl2.push_back(mk(4'b0000, 4'b1000, p4(ev(6,15), '0, '0, '0), ev(3,12), 5'd1, 0,
                      4'b0000, 4'b1000, 1, 0, ev(6,15), 16'd5));
    tbl2.push_back(mk(4'b0000, 4'b0000, '0, ev(3,12), 5'd2, 0, 4'b0000, 4'b0000, 0, 0, '0, 16'd5));
    tbl2.push_back(mk(4'b0000, 4'b0000, '0, ev(3,12), 5'd2, 0, 4'b0000, 4'b0000, 0, 0, '0, 16'd7));
    tbl2.push_back(mk(4'b0000, 4'b0000, '0, ev(4,3),  5'd3, 0, 4'b0000, 4'b0000, 0, 0, '0, 16'd7));
    tbl2.push_back(mk(4'b0000, 4'b0000, '0, ev(4,3),  5'd3, 0, 4'b0000, 4'b0000, 0, 0, '0, 16'd7));
    tbl2.push_back(mk(4'b0000, 4'b0101, p4('0, ev(1,18), '0, ev(0,20)), ev(4,3), 5'd3, 0,
                      4'b0000, 4'b0001, 1, 0, ev(0,20), 16'd7));
    tbl2.push_back(mk(4'b0000, 4'b0100, p4('0, ev(1,18), '0, ev(0,20)), ev(4,3), 5'd3, 0,
                      4'b0000, 4'b0100, 1, 0, ev(1,18), 16'd7));
    tbl2.push_back(mk(4'b1111, 4'b0000, '0, ev(0,0),  5'd0, 0, 4'b0000, 4'b0000, 0, 0, '0, 16'd7));

    // Reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy",    32'(busy),    32'd0);
    chk("reset gvt",     32'(gvt),     32'd0);
    chk("reset rtn_vld", 32'(rtn_vld), 32'd0);
    chk("reset err",     32'(err),     32'd0);
    chk("reset strobes", 32'({core_evt_vld, core_ack, q_enq, q_deq}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Run 1.
    end_time = 16'd20;
    start    = 1'b1;
    q_count  = 5'd4;
    @(negedge clk);
    chk("idle start q_enq", 32'(q_enq), 32'd0);
    chk("idle start busy",  32'(busy),  32'd0);
    @(posedge clk); #1;
    start    = 1'b0;
    end_time = 16'd0;
    for (int i = 0; i < NINIT; i++) begin
      @(negedge clk);
      chk($sformatf("init%0d q_enq", i),   32'(q_enq),   32'd1);
      chk($sformatf("init%0d q_wdata", i), 32'(q_wdata), 32'(ev(i, 0)));
      chk($sformatf("init%0d gvt", i),     32'(gvt),     32'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < tbl1.size(); i++) apply(tbl1[i], "run1_row", i);
    check_done("run1", 1'b0, 16'd22);

    // Run 2: seed 2 held off by q_full for three cycles.
    end_time = 16'd100;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    full_pat = 7'b0011100;
    seed_exp = 0;
    enq_cnt  = 0;
    for (int c = 0; c < 7; c++) begin
      q_full = full_pat[c];
      @(negedge clk);
      if (q_enq === 1'b1) enq_cnt++;
      chk($sformatf("stall%0d q_enq", c), 32'(q_enq), 32'(!full_pat[c]));
      chk($sformatf("stall%0d gvt", c),   32'(gvt),   32'd0);
      if (!full_pat[c]) begin
        chk($sformatf("stall%0d q_wdata", c), 32'(q_wdata), 32'(ev(seed_exp, 0)));
        seed_exp++;
      end
      @(posedge clk); #1;
    end
    q_full = 1'b0;
    chk("stall enq total", 32'(enq_cnt), 32'd4);
    for (int i = 0; i < tbl2.size(); i++) apply(tbl2[i], "run2_row", i);
    check_done("run2", 1'b1, 16'd7);

    // Run 3: reset asserted mid-INIT takes effect without a clock edge.
    end_time = 16'd50;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    @(negedge clk);
    chk("run3 busy before reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy",  32'(busy),  32'd0);
    chk("async reset q_enq", 32'(q_enq), 32'd0);
    chk("async reset gvt",   32'(gvt),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
